// File: rtl/inst_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch unit:
// FSM encodings, instruction/PC widths and the queued {pc, inst} entry.
package inst_fetch_unit_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned PC_W   = 32;
  localparam int unsigned PC_INC = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Memory request, redirect and decoder-side handshake bundle of the fetch unit.
interface inst_fetch_unit_if;
  import inst_fetch_unit_pkg::*;

  logic              mem_req;
  logic [PC_W-1:0]   mem_addr;
  logic              mem_ack;
  logic [INST_W-1:0] mem_rdata;
  logic              redirect;
  logic [PC_W-1:0]   redirect_pc;
  logic              inst_valid;
  logic [INST_W-1:0] inst;
  logic [PC_W-1:0]   inst_pc;
  logic              inst_ready;

  modport slave (
    output mem_req, mem_addr, inst_valid, inst, inst_pc,
    input  mem_ack, mem_rdata, redirect, redirect_pc, inst_ready
  );

  modport master (
    input  mem_req, mem_addr, inst_valid, inst, inst_pc,
    output mem_ack, mem_rdata, redirect, redirect_pc, inst_ready
  );

endinterface

// File: rtl/inst_fetch_unit_fifo.sv
// Prefetch queue: power-of-two ring buffer with a flush that wins over push/pop.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [W-1:0]           i_wdata,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output logic [W-1:0]           o_rdata,
  output logic                   o_valid,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_pop;

  assign w_do_pop = i_pop && (r_count != '0);

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: single-outstanding memory requester feeding a prefetch queue,
// with redirect flush and a DROP state that swallows the stale in-flight word.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input logic              clk,
  input logic              rst,
  inst_fetch_unit_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [PC_W-1:0]  r_fetch_pc;
  logic [PC_W-1:0]  w_fetch_pc_nxt;
  logic [PC_W-1:0]  r_mem_addr;
  logic [PC_W-1:0]  w_mem_addr_nxt;
  logic             r_mem_req;
  logic             w_mem_req_nxt;
  logic             r_rst_done;
  logic             w_push;
  logic             w_pop;
  logic             w_flush;
  logic             w_valid;
  logic             w_room;
  logic [CNT_W-1:0] w_count;
  fetch_entry_t     w_wr_entry;
  fetch_entry_t     w_head;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(fetch_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_wr_entry),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_rdata (w_head),
    .o_valid (w_valid),
    .o_count (w_count)
  );

  assign w_pop  = w_valid && bus.inst_ready;
  assign w_room = (w_count + CNT_W'(1)) <= CNT_W'(DEPTH);

  // Next state, fetch PC, request address and queue control
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_mem_addr_nxt = r_mem_addr;
    w_push         = 1'b0;
    w_flush        = bus.redirect;
    w_wr_entry     = '{pc: r_mem_addr, inst: bus.mem_rdata};
    case (r_state)
      ST_IDLE: begin
        if (bus.redirect) begin
          w_fetch_pc_nxt = bus.redirect_pc;
        end else if (r_rst_done && w_room) begin
          w_state_nxt    = ST_WAIT;
          w_mem_addr_nxt = r_fetch_pc;
        end
      end
      ST_WAIT: begin
        if (bus.redirect) begin
          w_fetch_pc_nxt = bus.redirect_pc;
          w_state_nxt    = bus.mem_ack ? ST_IDLE : ST_DROP;
        end else if (bus.mem_ack) begin
          w_push         = 1'b1;
          w_fetch_pc_nxt = r_fetch_pc + PC_W'(PC_INC);
          w_state_nxt    = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (bus.redirect) w_fetch_pc_nxt = bus.redirect_pc;
        if (bus.mem_ack) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_mem_req_nxt = (w_state_nxt != ST_IDLE);
  end

  // r_rst_done holds off the first request by one cycle after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_fetch_pc <= RESET_PC;
      r_mem_addr <= '0;
      r_mem_req  <= 1'b0;
      r_rst_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_mem_req  <= w_mem_req_nxt;
      r_rst_done <= 1'b1;
    end
  end

  assign bus.mem_req    = r_mem_req;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.inst_valid = w_valid;
  assign bus.inst       = w_head.inst;
  assign bus.inst_pc    = w_head.pc;

endmodule

// File: doc/inst_fetch_unit.md
INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 Parameter DEPTH, default 4, sets the prefetch queue depth in entries; it SHALL be a power of two and at least 2.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, sets the first fetch address after reset.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port mem_req, output, 1 bit: instruction-memory read request.
REQ-006 Port mem_addr, output, 32 bits: byte address of the requested word.
REQ-007 Port mem_ack, input, 1 bit: memory completion strobe, valid for one cycle.
REQ-008 Port mem_rdata, input, 32 bits: instruction word, valid when mem_ack=1.
REQ-009 Port redirect, input, 1 bit: one-cycle pulse from the data path signalling a jump, branch or jal.
REQ-010 Port redirect_pc, input, 32 bits: new fetch target, valid when redirect=1.
REQ-011 Port inst_valid, output, 1 bit: the queue head holds an instruction.
REQ-012 Port inst, output, 32 bits: queue-head instruction, consumed by the decoder and controller.
REQ-013 Port inst_pc, output, 32 bits: address of the queue-head instruction, used for pc_to_reg and jal.
REQ-014 Port inst_ready, input, 1 bit: the consumer accepts the head this cycle.

Function
REQ-015 The FIFO SHALL hold {pc, inst} pairs; inst, inst_pc and inst_valid=(count!=0) SHALL be driven combinationally from the head entry.
REQ-016 A pop SHALL occur on a clock edge when inst_valid=1 and inst_ready=1.
REQ-017 The FSM SHALL have three states: IDLE, WAIT and DROP; mem_req SHALL be 1 exactly in WAIT and DROP.
REQ-018 IDLE->WAIT: when count plus one outstanding request is at most DEPTH and redirect=0; mem_addr SHALL latch fetch_pc on this transition.
REQ-019 Once mem_req=1, mem_addr SHALL stay stable until the cycle mem_ack=1; a request SHALL never be withdrawn.
REQ-020 WAIT with mem_ack=1: push {mem_addr, mem_rdata}, set fetch_pc to fetch_pc+4 (mod 2^32, wraps 32'hFFFF_FFFC->0), then move to IDLE.
REQ-021 There SHALL be at most one outstanding request, so a push can never overflow the queue.
REQ-022 Latency: an ack in cycle N SHALL produce inst_valid=1 in cycle N+1 if the queue was empty; with mem_ack tied high the throughput SHALL be one instruction per two cycles.
REQ-023 On redirect=1 the unit SHALL flush the queue (count to 0) and load fetch_pc with redirect_pc.
REQ-024 Redirect in IDLE or WAIT with mem_ack=1: go to IDLE and discard the acked data.
REQ-025 Redirect in WAIT with mem_ack=0: go to DROP.
REQ-026 DROP: hold mem_req, discard data on mem_ack, then go to IDLE; a further redirect in DROP SHALL only update fetch_pc.
REQ-027 Redirect SHALL take priority over a same-cycle push and pop; the popped instruction counts as consumed, and inst_valid SHALL be 0 in the next cycle.
REQ-028 A same-cycle push and pop SHALL leave count unchanged, including when count=DEPTH-1.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-030 While rst=0: state=IDLE, count=0, pointers=0, fetch_pc=RESET_PC, mem_req=0, mem_addr=0, inst_valid=0.
REQ-031 Reset asserted mid-request SHALL abandon the request; any mem_ack arriving after release while in IDLE SHALL be ignored.
REQ-032 The first mem_req SHALL assert in the second rising edge after rst deasserts.

Structure
REQ-033 The FSM state encodings and the instruction-width and PC-increment constants SHALL live in the shared processor package.
REQ-034 The queue SHALL be a sub-module named fetch_fifo (parameter DEPTH, width 64), holding storage, pointers and count; FSM and PC logic SHALL remain in inst_fetch_unit.

Verification
REQ-035 Reset release, memory acks after 1 cycle, inst_ready=1 -> mem_addr sequence 0,4,8,C, and inst_pc follows in order with matching inst.
REQ-036 inst_ready=0, DEPTH=4 -> exactly 4 requests then mem_req stays 0 while count=4; one pop -> exactly one new request.
REQ-037 Redirect to 32'h0000_0100 while a request is pending -> DROP, the stale ack is discarded, the next mem_addr is 0x100, and no stale instruction appears on inst.
REQ-038 Redirect in the same cycle as mem_ack and a pop -> queue empty next cycle, next request at redirect_pc.
REQ-039 fetch_pc=32'hFFFF_FFFC -> next mem_addr=32'h0000_0000.
REQ-040 rst pulsed low mid-WAIT with a later ack -> all outputs at reset values, fetch restarts at RESET_PC, and the late ack is ignored.
